fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the control decoder. Holds the program counter, issues word requests to instruction memory over a valid/ready handshake, and presents each fetched instruction with its PC and pre-split `op`/`func3`/`func7` fields to decode under a valid/ready handshake. Supports PC redirect from execute and discards stale in-flight responses.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: first fetch address. Must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out XLEN: word address of the request, equal to the current PC.
- `imem_rsp_valid` in 1: response data valid.
- `imem_rsp_data` in 32: instruction word.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode consumes the instruction.
- `instr` out 32: registered instruction word.
- `instr_pc` out XLEN: PC of `instr`.
- `op` out 7: `instr[6:0]`.
- `func3` out 3: `instr[14:12]`.
- `func7` out 7: `instr[31:25]`.
- `redirect_valid` in 1: one-cycle pulse that replaces the PC.
- `redirect_pc` in XLEN: new PC.
- `fault` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- **Memory contract:** exactly one response per accepted request, in order, no earlier than the cycle after acceptance. At most one request is outstanding.
- **FSM states:** IDLE, REQ, WAIT, HOLD, plus FAULT when the macro is enabled.
- **IDLE:** entered on reset. Moves to REQ after 1 cycle.
- **REQ:** `imem_req_valid`=1 and `imem_req_addr`=`pc`. When `imem_req_ready`=1, moves to WAIT.
- **WAIT:** when `imem_rsp_valid`=1:
  - `instr` ← data and `instr_pc` ← `pc`.
  - `pc` ← `pc`+4, wrapping modulo 2^XLEN.
  - Moves to HOLD.
- **HOLD:** `instr_valid`=1, with all outputs stable until `instr_ready`=1. Then moves to REQ.
- **Redirect** has highest priority; `pc` ← `redirect_pc` in every state except FAULT.
  - REQ, not accepted this cycle: stay in REQ; the new PC is requested next cycle.
  - REQ, accepted the same cycle: go to WAIT with `discard`=1.
  - WAIT, no response this cycle: set `discard`=1. The next response is dropped, with no state update, and the FSM returns to REQ.
  - WAIT, response the same cycle: drop it and go to REQ.
  - HOLD: `instr_valid` drops the next cycle and the FSM goes to REQ. If `instr_ready`=1 in the same cycle, that handshake still completes.
- **Field outputs:** `op`/`func3`/`func7` are combinational slices of the registered `instr`.

## Timing
- **Reset values:**
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `op`/`func3`/`func7`=0, `fault`=0.
  - `pc`=`RESET_PC`, `discard`=0.
- **Best-case throughput:** one instruction per 3 cycles (REQ → WAIT → HOLD) with zero-wait memory and `instr_ready` high.
- **First `instr_valid` after reset release:** at the earliest cycle 4 (IDLE, REQ, WAIT, HOLD).
- **Reset mid-operation:** immediate return to IDLE. Any later response to the aborted request is a memory-side violation; memory must be reset together with the fetch unit.
- **Handshake rule:** `instr_valid` never drops without either a `instr_ready` handshake or a redirect.

## Configuration
- **Macro:** `FETCH_ALIGN_CHECK_EN`.
- **Defined:**
  - A redirect with `redirect_pc[1:0]`≠0 sets `fault`=1 on the next edge.
  - The FSM enters FAULT: no requests, `instr_valid`=0, redirects ignored.
  - Only reset clears it.
- **Undefined:**
  - `redirect_pc[1:0]` is forced to 00.
  - `fault` is tied to 0 and the FAULT state does not exist.

## Test plan
- **Reset fetch:** reset release with zero-wait memory returning 0x00500093 and `instr_ready`=1 → requests to 0x0, then 0x4. First instr has `instr_pc`=0, `op`=0x13, `func3`=0, `func7`=0.
- **Decode backpressure:** `instr_ready`=0 for 5 cycles with `instr`=0x002081B3 → `instr_valid` and `instr` held stable. No new request until the handshake; the next address is 0x4.
- **Redirect in WAIT:** redirect to 0x100 while the response is 3 cycles away → that response is dropped and the next request address is 0x100. `instr_pc` of the next delivered instruction is 0x100.
- **Redirect with same-cycle acceptance:** redirect coinciding with `imem_req_ready` → the stale response is discarded and a request to the redirect address follows.
- **PC wrap:** `RESET_PC`=0xFFFF_FFFC → the second request address is 0x0000_0000.
- **Misaligned redirect:** redirect to 0x102.
  - With `FETCH_ALIGN_CHECK_EN`: `fault`=1, no further `imem_req_valid` until reset.
  - Without it: the request address is 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the RISC-V core.
// Holds the PC, issues one word request at a time to instruction memory,
// and hands each fetched instruction (with its PC and pre-split op/func3/
// func7 fields) to decode. Redirects from execute replace the PC and cause
// any stale in-flight response to be dropped.
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets (sticky fault, FAULT state). Without it the low two bits of the
// redirect target are forced to 00 and fault is tied low.
//
// Handshake semantics (both the imem request and the decode channel):
// a transfer happens on a rising edge where valid and ready are both 1.
// Once valid is raised, it and its payload stay stable until the transfer,
// except that a redirect may withdraw an instruction offered to decode.
// Memory returns exactly one response per accepted request, in order, no
// earlier than the cycle after acceptance.

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory request
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    // instruction memory response
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    // decode side
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    // status
    output logic            fault,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [2:0] S_FAULT = 3'd4;
`endif

    logic [2:0]      state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [31:0]     instr_q,    instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            discard_q,  discard_d;

    // Redirect qualification: redir_take means the PC is replaced this cycle.
    logic            redir_take;
    logic [XLEN-1:0] redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redir_bad;

    // A misaligned target is trapped instead of being followed; the FAULT
    // state ignores all further redirects.
    always_comb begin
        redir_bad    = redirect_valid && (state_q != S_FAULT) &&
                       (redirect_pc[1:0] != 2'b00);
        redir_take   = redirect_valid && (state_q != S_FAULT) && !redir_bad;
        redir_target = redirect_pc;
    end
`else
    logic unused_redir_lsb;

    // Without the check the target is simply forced to word alignment.
    always_comb begin
        redir_take   = redirect_valid;
        redir_target = {redirect_pc[XLEN-1:2], 2'b00};
    end
    assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

    // Next-state logic: normal fetch sequencing, then redirect overlay on top.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        discard_d  = discard_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_q) begin
                        // Stale response from before a redirect: drop it.
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redir_take) begin
            pc_d = redir_target;
            case (state_q)
                S_REQ: begin
                    // Accepted request now fetches the old PC; drop its reply.
                    if (imem_req_ready) begin
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        // Reply arriving now is stale: keep previous instr.
                        instr_d    = instr_q;
                        instr_pc_d = instr_pc_q;
                        discard_d  = 1'b0;
                        state_d    = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_REQ;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end

`ifdef FETCH_ALIGN_CHECK_EN
        if (redir_bad) begin
            fault_d   = 1'b1;
            discard_d = 1'b0;
            state_d   = S_FAULT;
        end
`endif
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign op             = instr_q[6:0];
    assign func3          = instr_q[14:12];
    assign func7          = instr_q[31:25];
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a cycle table of inputs and hand-derived
// expected outputs, followed by hand-written misaligned-redirect and
// reset-mid-operation sequences. A second instance with RESET_PC=0xFFFFFFFC
// shares the inputs and runs in lockstep to exercise PC wrap.

module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        rdv;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        c2;
        logic [31:0] e_addr2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        req_valid, req_valid2;
    logic [31:0] req_addr, req_addr2;
    logic        ivalid, ivalid2;
    logic [31:0] instr, instr2, ipc, ipc2;
    logic [6:0]  op, op2, f7, f72;
    logic [2:0]  f3, f32;
    logic        fault, fault2;
    logic [2:0]  dbg, dbg2;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(ivalid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(ipc), .op(op), .func3(f3), .func7(f7),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault), .dbg_state(dbg)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr2),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(ivalid2), .instr_ready(instr_ready),
        .instr(instr2), .instr_pc(ipc2), .op(op2), .func3(f32), .func7(f72),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault2), .dbg_state(dbg2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] rs, rr, rv, rd, ir, rdv, rpc,
                               erv, ea, eiv, ei, eip, c2, e2);
        vec_t r;
        r.rst = rs[0];  r.rr = rr[0];  r.rv = rv[0];  r.rd = rd;
        r.ir = ir[0];   r.rdv = rdv[0]; r.rpc = rpc;
        r.e_rv = erv[0]; r.e_addr = ea; r.e_iv = eiv[0];
        r.e_instr = ei; r.e_ipc = eip; r.c2 = c2[0]; r.e_addr2 = e2;
        return r;
    endfunction

    task automatic drive(input logic rs, rr, rv, input logic [31:0] rd,
                         input logic ir, rdv, input logic [31:0] rpc);
        rst = rs; imem_req_ready = rr; imem_rsp_valid = rv; imem_rsp_data = rd;
        instr_ready = ir; redirect_valid = rdv; redirect_pc = rpc;
    endtask

    initial begin
        // --- reset fetch, plus wrap on the second instance
        tbl.push_back(v(1,0,0,0,0,0,0,           0,0,0,0,0,                       1,32'hFFFF_FFFC));
        tbl.push_back(v(0,1,0,0,1,0,0,           0,0,0,0,0,                       0,0));
        tbl.push_back(v(0,1,0,0,1,0,0,           1,0,0,0,0,                       1,32'hFFFF_FFFC));
        tbl.push_back(v(0,1,1,32'h00500093,1,0,0,0,0,0,0,0,                       0,0));
        tbl.push_back(v(0,1,0,0,1,0,0,           0,4,1,32'h00500093,0,            1,0));
        tbl.push_back(v(0,1,0,0,1,0,0,           1,4,0,32'h00500093,0,            1,0));
        tbl.push_back(v(0,1,1,32'h00A00113,1,0,0,0,4,0,32'h00500093,0,            0,0));
        tbl.push_back(v(0,1,0,0,1,0,0,           0,8,1,32'h00A00113,4,            1,4));
        // --- decode backpressure on the first instruction after reset
        tbl.push_back(v(1,0,0,0,0,0,0,           0,0,0,0,0,                       0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           0,0,0,0,0,                       0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,0,0,0,0,                       0,0));
        tbl.push_back(v(0,1,1,32'h002081B3,0,0,0,0,0,0,0,0,                       0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(v(0,1,0,0,0,0,0,       0,4,1,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,1,0,0,1,0,0,           0,4,1,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,           1,4,0,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,4,0,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,           0,4,0,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,0,1,32'h40208133,0,0,0,0,4,0,32'h002081B3,0,            0,0));
        tbl.push_back(v(0,0,0,0,1,0,0,           0,8,1,32'h40208133,4,            0,0));
        // --- redirect in WAIT, stale response three cycles later
        tbl.push_back(v(0,1,0,0,0,0,0,           1,8,0,32'h40208133,4,            0,0));
        tbl.push_back(v(0,0,0,0,0,1,32'h100,     0,8,0,32'h40208133,4,            0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,           0,32'h100,0,32'h40208133,4,      0,0));
        tbl.push_back(v(0,0,1,32'hDEADBEEF,0,0,0,0,32'h100,0,32'h40208133,4,      0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,32'h100,0,32'h40208133,4,      0,0));
        tbl.push_back(v(0,0,1,32'h00100093,0,0,0,0,32'h100,0,32'h40208133,4,      0,0));
        tbl.push_back(v(0,0,0,0,1,0,0,           0,32'h104,1,32'h00100093,32'h100,0,0));
        // --- redirect with same-cycle acceptance
        tbl.push_back(v(0,1,0,0,0,1,32'h200,     1,32'h104,0,32'h00100093,32'h100,0,0));
        tbl.push_back(v(0,0,1,32'hBAD0BAD0,0,0,0,0,32'h200,0,32'h00100093,32'h100,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,32'h200,0,32'h00100093,32'h100,0,0));
        tbl.push_back(v(0,0,1,32'h00208063,0,0,0,0,32'h200,0,32'h00100093,32'h100,0,0));
        // --- redirect in HOLD, in REQ without acceptance, in WAIT with response
        tbl.push_back(v(0,0,0,0,0,1,32'h300,     0,32'h204,1,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,0,0,0,0,1,32'h400,     1,32'h300,0,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,32'h400,0,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,0,1,32'hCAFEF00D,0,1,32'h500,0,32'h400,0,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0,           1,32'h500,0,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,0,1,32'h0000006F,0,0,0,0,32'h500,0,32'h00208063,32'h200,0,0));
        tbl.push_back(v(0,0,0,0,1,0,0,           0,32'h504,1,32'h0000006F,32'h500,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,           1,32'h504,0,32'h0000006F,32'h500,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rr, tbl[i].rv, tbl[i].rd,
                  tbl[i].ir, tbl[i].rdv, tbl[i].rpc);
            #1;
            chk($sformatf("row%0d req_valid", i), {31'b0, req_valid}, {31'b0, tbl[i].e_rv});
            chk($sformatf("row%0d req_addr", i), req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), {31'b0, ivalid}, {31'b0, tbl[i].e_iv});
            chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
            chk($sformatf("row%0d instr_pc", i), ipc, tbl[i].e_ipc);
            chk($sformatf("row%0d op", i), {25'b0, op}, {25'b0, tbl[i].e_instr[6:0]});
            chk($sformatf("row%0d func3", i), {29'b0, f3}, {29'b0, tbl[i].e_instr[14:12]});
            chk($sformatf("row%0d func7", i), {25'b0, f7}, {25'b0, tbl[i].e_instr[31:25]});
            chk($sformatf("row%0d fault", i), {31'b0, fault}, 32'd0);
            if (tbl[i].c2)
                chk($sformatf("row%0d wrap_addr", i), req_addr2, tbl[i].e_addr2);
        end

        // --- misaligned redirect to 0x102 while in REQ at 0x504
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            // an aligned redirect mid-way must be ignored in FAULT
            drive(0, 1, 0, 0, 1, (c == 2), 32'h200);
            #1;
            chk($sformatf("mis%0d fault", c), {31'b0, fault}, 32'd1);
            chk($sformatf("mis%0d req_valid", c), {31'b0, req_valid}, 32'd0);
            chk($sformatf("mis%0d instr_valid", c), {31'b0, ivalid}, 32'd0);
        end
`else
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("mis req_valid", {31'b0, req_valid}, 32'd1);
        chk("mis req_addr", req_addr, 32'h100);
        chk("mis fault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        drive(0, 0, 1, 32'h00000013, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("mis instr_valid", {31'b0, ivalid}, 32'd1);
        chk("mis instr_pc", ipc, 32'h100);
        chk("mis instr", instr, 32'h00000013);
`endif

        // --- reset in the middle of operation
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst req_addr", req_addr, 32'h0);
        chk("rst instr_valid", {31'b0, ivalid}, 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst instr_pc", ipc, 32'h0);
        chk("rst op", {25'b0, op}, 32'd0);
        chk("rst fault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rel idle req_valid", {31'b0, req_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rel req_valid", {31'b0, req_valid}, 32'd1);
        chk("rel req_addr", req_addr, 32'h0);
        chk("rel wrap req_addr", req_addr2, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
